tao_xung_ctrl: RTL and testbench
================================

Name: tao_xung_ctrl

Overview:
- Programmable controller/scheduler for a 3-output pulse generator.
- Owns per-channel period and high-time registers and runs one counter per channel.
- Accepts configuration over a valid/ready port and drives clko[2:0].
- Configuration changes are applied only at period boundaries, so outputs never glitch or truncate a period.

Parameters:
CW, 16, counter/config width in clki cycles
NCH, 3, number of pulse channels

Ports:
clki  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
cfg_ch  in  2  target channel
cfg_period  in  CW  period in clki cycles
cfg_high  in  CW  high-time in clki cycles
cfg_en  in  1  1 = run channel, 0 = stop channel
cfg_err  out  1  one-cycle pulse: request rejected
clko  out  NCH  pulse outputs, registered
wrap  out  NCH  one-cycle strobe in last cycle of each period
busy  out  NCH  channel in RUN

Behaviour:
- Reset (sync, active-high): all channels IDLE; cnt=0; active/shadow regs=0; pending=0; clko=0, wrap=0, busy=0, cfg_err=0.
- Reset asserted mid-operation: same values on the next edge; pending updates are discarded.
- cfg_ready:
  - Combinational: cfg_ready = !pending[cfg_ch] when cfg_ch<NCH.
  - cfg_ready = 1 when cfg_ch>=NCH, so the request is accepted and then rejected.
  - cfg_ready = 1 during reset release.
- Validation on accept: legal iff cfg_ch<NCH && cfg_period>=2 && cfg_high<=cfg_period.
  - Illegal: cfg_err=1 on the following cycle; no state changes.
  - cfg_en=0 requests are validated only on cfg_ch; period/high are ignored.
- Channel FSM has two states, IDLE and RUN.
- IDLE:
  - clko=0, busy=0, cnt=0.
  - Legal accept with en=1: load active regs, enter RUN next edge with cnt=0.
  - Legal accept with en=0: accepted, no effect.
- RUN:
  - busy=1.
  - cnt increments each cycle and wraps from period_act-1 to 0.
  - In the cycle where cnt==k, clko = (k < high_act).
  - First high cycle is the cycle immediately after the accepting edge (latency 1).
  - wrap=1 in the cycle where cnt==period_act-1.
- Duty extremes:
  - high_act=0: clko stays constant 0.
  - high_act=period_act: clko stays constant 1.
  - wrap pulses normally in both cases.
- Update to a RUN channel:
  - Legal accept writes the shadow regs and sets pending.
  - At the next wrap edge: active <= shadow, pending cleared, cnt <= 0.
  - If shadow en=0, the channel goes to IDLE at that edge; clko=0 from the next cycle.
- Accept in the same cycle as that channel's wrap: bypasses the shadow and is applied at this same boundary; pending is never set.
- Channels are fully independent; simultaneous wraps on several channels are legal.
- No arithmetic overflow: cnt is CW bits, compared strictly below period_act (at most 2^CW-1).

Decomposition:
- Package tao_xung_pkg holds:
  - CW, NCH, MIN_PERIOD=2
  - channel state encoding (ST_IDLE, ST_RUN)
  - channel config struct/typedef {period, high, en}
- Sub-module tao_xung_kenh contains one channel: FSM, counter, active/shadow regs, pending, clko/wrap/busy flops.
  - It is instantiated NCH times via generate.
- The top level holds cfg validation, channel decode, cfg_ready mux and cfg_err.

Test Plan:
1. Reset, then accept ch0 period=4 high=2 en=1 -> clko[0]=1,1,0,0 repeating from the next cycle; wrap[0] every 4th cycle aligned with the 4th; busy[0]=1.
2. ch1 running period=5 high=1; mid-period write period=3 high=2 -> current 5-cycle period completes unchanged, then 1,1,0 pattern; cfg_ready low for ch1 while pending; second ch1 write stalls until the boundary.
3. Illegal requests period=1, high=5 with period=4, ch=3 -> each accepted and cfg_err pulses one cycle later; no clko/busy change on any channel.
4. ch2 high=0 period=3 -> clko[2] constant 0 with wrap[2] every 3 cycles; then high=3 period=3 -> constant 1 after the boundary.
5. en=0 to running ch0 -> stops at the next wrap edge, clko[0]=0 and busy[0]=0 afterwards; a cfg accepted exactly in the wrap cycle is applied at that boundary.
6. All three channels running, rst pulsed one cycle mid-period with a pending update -> all outputs 0 next cycle, pending lost, IDLE until reconfigured.

Source files
------------

// File: rtl/tao_xung_pkg.sv
// Shared constants, channel state encoding and config record for the
// three-channel pulse generator controller.
package tao_xung_pkg;

  localparam int CW  = 16;  // counter / config width in clock cycles
  localparam int NCH = 3;   // number of pulse channels
  localparam int CHW = 2;   // width of the channel select field

  localparam logic [CW-1:0] MIN_PERIOD = CW'(2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic          en;
  } chan_cfg_t;

  // A stop request only needs a real channel; a run request also needs
  // a period of at least two cycles and a high time that fits in it.
  function automatic logic cfg_is_legal(input logic [CHW-1:0] ch, input chan_cfg_t c);
    logic ch_ok;
    ch_ok = (int'(ch) < NCH);
    return ch_ok && (!c.en || ((c.period >= MIN_PERIOD) && (c.high <= c.period)));
  endfunction

endpackage

// File: rtl/tao_xung_kenh.sv
// One pulse channel: IDLE/RUN FSM, period counter, active and shadow
// configuration, and registered clko/wrap outputs. New settings for a
// running channel only take effect on the edge that ends a period.
module tao_xung_kenh
  import tao_xung_pkg::*;
(
  input  logic      clk,
  input  logic      srst,
  input  logic      wr,       // legal accepted request for this channel
  input  chan_cfg_t cfg,
  output logic      pending,
  output logic      clko,
  output logic      wrap,
  output logic      busy
);

  chan_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  chan_cfg_t     act_reg, act_next;
  chan_cfg_t     shd_reg, shd_next;
  logic          pend_reg, pend_next;
  logic          clko_reg, clko_next;
  logic          wrap_reg, wrap_next;

  // State, counter, config and output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      act_reg   <= '0;
      shd_reg   <= '0;
      pend_reg  <= 1'b0;
      clko_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      shd_reg   <= shd_next;
      pend_reg  <= pend_next;
      clko_reg  <= clko_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next-state logic; clko/wrap are computed from the next counter value
  // so the registered outputs line up with the counter they describe.
  always_comb begin
    logic      at_wrap;
    chan_cfg_t cfg_sel;

    state_next = state_reg;
    cnt_next   = cnt_reg;
    act_next   = act_reg;
    shd_next   = shd_reg;
    pend_next  = pend_reg;
    clko_next  = 1'b0;
    wrap_next  = 1'b0;
    cfg_sel    = act_reg;
    at_wrap    = (cnt_reg == (act_reg.period - CW'(1)));

    case (state_reg)
      ST_IDLE: begin
        if (wr && cfg.en) begin
          state_next = ST_RUN;
          act_next   = cfg;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (at_wrap) begin
          // A request landing on the last cycle of a period skips the
          // shadow and takes effect at this very boundary.
          if (wr) begin
            cfg_sel = cfg;
          end else if (pend_reg) begin
            cfg_sel = shd_reg;
          end
          act_next  = cfg_sel;
          pend_next = 1'b0;
          cnt_next  = '0;
          if (!cfg_sel.en) begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (wr) begin
            shd_next  = cfg;
            pend_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next == ST_RUN) begin
      clko_next = (cnt_next < act_next.high);
      wrap_next = (cnt_next == (act_next.period - CW'(1)));
    end
  end

  assign pending = pend_reg;
  assign clko    = clko_reg;
  assign wrap    = wrap_reg;
  assign busy    = (state_reg == ST_RUN);

endmodule

// File: rtl/tao_xung_ctrl.sv
// Pulse generator controller: validates configuration requests, routes
// legal ones to the addressed channel and reports rejected ones on cfg_err.
module tao_xung_ctrl
  import tao_xung_pkg::*;
(
  input  logic           clki,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic           cfg_en,
  output logic           cfg_err,
  output logic [NCH-1:0] clko,
  output logic [NCH-1:0] wrap,
  output logic [NCH-1:0] busy
);

  chan_cfg_t      cfg_in;
  logic           accept;
  logic           legal;
  logic           ready_mux;
  logic           cfg_err_reg;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;

  assign cfg_in = '{period: cfg_period, high: cfg_high, en: cfg_en};
  assign legal  = cfg_is_legal(cfg_ch, cfg_in);
  assign accept = cfg_valid && cfg_ready;

  // A channel with an update waiting back-pressures further writes to it;
  // out-of-range channels are always accepted so they can be rejected.
  always_comb begin
    ready_mux = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) begin
        ready_mux = !pending[i];
      end
    end
  end

  assign cfg_ready = rst | ready_mux;

  // Rejection strobe, one cycle after the accepting edge.
  always_ff @(posedge clki) begin
    if (rst) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= accept && !legal;
    end
  end

  assign cfg_err = cfg_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_kenh
      assign wr[gi] = accept && legal && (cfg_ch == CHW'(gi));

      tao_xung_kenh u_kenh (
        .clk     (clki),
        .srst    (rst),
        .wr      (wr[gi]),
        .cfg     (cfg_in),
        .pending (pending[gi]),
        .clko    (clko[gi]),
        .wrap    (wrap[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tao_xung_ctrl.sv
// Testbench for tao_xung_ctrl: directed scenarios plus random traffic,
// checked each cycle against a period/phase reference model.
module tb_tao_xung_ctrl;
  import tao_xung_pkg::*;

  logic           clki = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [CW-1:0]  cfg_high;
  logic           cfg_en;
  logic           cfg_err;
  logic [NCH-1:0] clko;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] busy;

  tao_xung_ctrl dut (
    .clki       (clki),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_en     (cfg_en),
    .cfg_err    (cfg_err),
    .clko       (clko),
    .wrap       (wrap),
    .busy       (busy)
  );

  always #5 clki = ~clki;

  int errors = 0;
  int checks = 0;

  // expected {clko, wrap, busy, cfg_err} for each upcoming cycle
  logic [3*NCH:0] exp_q[$];

  // reference model: each channel is running or not, with a phase inside its period
  bit mrun[NCH];
  int mper[NCH];
  int mhi[NCH];
  int mpos[NCH];
  bit mpend[NCH];
  int sper[NCH];
  int shi[NCH];
  bit sen[NCH];
  bit merr;

  function automatic bit model_ready();
    int ch;
    ch = int'(cfg_ch);
    if (rst) return 1'b1;
    if (ch >= NCH) return 1'b1;
    return !mpend[ch];
  endfunction

  function automatic logic [3*NCH:0] exp_frame();
    logic [NCH-1:0] c;
    logic [NCH-1:0] w;
    logic [NCH-1:0] b;
    c = '0;
    w = '0;
    b = '0;
    for (int i = 0; i < NCH; i++) begin
      c[i] = mrun[i] && (mpos[i] < mhi[i]);
      w[i] = mrun[i] && (mpos[i] == mper[i] - 1);
      b[i] = mrun[i];
    end
    return {c, w, b, merr};
  endfunction

  task automatic model_step();
    int  ch;
    int  p;
    int  h;
    bit  acc;
    bit  legal;
    bit  hit;
    ch = int'(cfg_ch);
    p  = int'(cfg_period);
    h  = int'(cfg_high);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mrun[i] = 0; mper[i] = 0; mhi[i] = 0; mpos[i] = 0;
        mpend[i] = 0; sper[i] = 0; shi[i] = 0; sen[i] = 0;
      end
      merr = 0;
      return;
    end
    acc   = cfg_valid && model_ready();
    legal = (ch < NCH) && (!cfg_en || (p >= 2 && h <= p));
    merr  = acc && !legal;
    if (acc)
      $display("cfg ch=%0d period=%0d high=%0d en=%0d -> %s", ch, p, h, cfg_en, legal ? "legal" : "rejected");
    for (int i = 0; i < NCH; i++) begin
      hit = acc && legal && (ch == i);
      if (!mrun[i]) begin
        if (hit && cfg_en) begin
          mrun[i] = 1; mper[i] = p; mhi[i] = h; mpos[i] = 0;
        end
      end else if (mpos[i] == mper[i] - 1) begin
        if (hit) begin
          mper[i] = p; mhi[i] = h; mrun[i] = cfg_en;
        end else if (mpend[i]) begin
          mper[i] = sper[i]; mhi[i] = shi[i]; mrun[i] = sen[i];
        end
        mpend[i] = 0;
        mpos[i]  = 0;
      end else begin
        mpos[i] = mpos[i] + 1;
        if (hit) begin
          sper[i] = p; shi[i] = h; sen[i] = cfg_en; mpend[i] = 1;
        end
      end
    end
  endtask

  // One clock cycle with the inputs currently driven; entered and left at posedge+2.
  task automatic tick();
    logic [3*NCH:0] f;
    #1;
    checks++;
    if (cfg_ready !== model_ready()) begin
      errors++;
      $display("FAIL cfg_ready: got %b required %b (ch=%0d)", cfg_ready, model_ready(), cfg_ch);
    end
    model_step();
    f = exp_frame();
    @(posedge clki);
    exp_q.push_back(f);
    #2;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int ch, input int p, input int h, input bit en);
    bit done;
    done       = 0;
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = CW'(p);
    cfg_high   = CW'(h);
    cfg_en     = en;
    for (int n = 0; n < 64 && !done; n++) begin
      done = model_ready();
      tick();
    end
    cfg_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: ch=%0d still not accepted after 64 cycles, required acceptance", ch);
    end
  endtask

  task automatic wait_wrap(input int ch);
    int n;
    n = 0;
    while (!(mrun[ch] && mpos[ch] == mper[ch] - 1) && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL wait_wrap: ch=%0d no period boundary within 64 cycles, required one", ch);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  // Monitor: compare every cycle's outputs with the frame the model queued for it.
  always @(negedge clki) begin
    logic [3*NCH:0] f;
    if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
      checks++;
      if ({clko, wrap, busy, cfg_err} !== f) begin
        errors++;
        $display("FAIL frame @%0t: got clko=%b wrap=%b busy=%b err=%b required clko=%b wrap=%b busy=%b err=%b",
                 $time, clko, wrap, busy, cfg_err,
                 f[3*NCH:2*NCH+1], f[2*NCH:NCH+1], f[NCH:1], f[0]);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_en     = 1'b0;
    @(posedge clki);
    #2;
    tick();
    rst = 1'b0;
    check_vec("reset_busy", busy, '0);
    check_vec("reset_clko", clko, '0);
    check_bit("reset_err", cfg_err, 1'b0);

    // 1: ch0 period 4 high 2 -> 1,1,0,0 with wrap on the 4th cycle
    send(0, 4, 2, 1);
    for (int k = 0; k < 8; k++) begin
      check_bit($sformatf("s1_clko_k%0d", k), clko[0], (k % 4) < 2);
      check_bit($sformatf("s1_wrap_k%0d", k), wrap[0], (k % 4) == 3);
      check_bit($sformatf("s1_busy_k%0d", k), busy[0], 1'b1);
      tick();
    end

    // 2: mid-period update on ch1, then a second write that must stall
    send(1, 5, 1, 1);
    idle(2);
    send(1, 3, 2, 1);
    send(1, 3, 1, 1);
    idle(8);

    // 3: illegal requests
    send(0, 1, 0, 1);
    send(1, 4, 5, 1);
    send(3, 4, 2, 1);
    idle(3);

    // 4: duty extremes on ch2
    send(2, 3, 0, 1);
    idle(7);
    send(2, 3, 3, 1);
    idle(8);

    // 5: request on the wrap cycle, then stop ch0
    wait_wrap(0);
    check_bit("s5_wrap_cycle", wrap[0], 1'b1);
    send(0, 6, 3, 1);
    idle(3);
    send(0, 6, 3, 0);
    idle(10);
    check_bit("s5_stopped_busy", busy[0], 1'b0);
    check_bit("s5_stopped_clko", clko[0], 1'b0);

    // 6: reset in the middle of activity with an update pending
    send(0, 5, 2, 1);
    send(1, 7, 3, 1);
    send(2, 4, 1, 1);
    idle(2);
    send(1, 3, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_vec("s6_clko", clko, '0);
    check_vec("s6_wrap", wrap, '0);
    check_vec("s6_busy", busy, '0);
    idle(6);
    check_vec("s6_still_idle", busy, '0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      if (cfg_valid) begin
        int p;
        p          = $urandom_range(0, 9);
        cfg_ch     = 2'($urandom_range(0, 3));
        cfg_period = CW'(p);
        cfg_high   = CW'($urandom_range(0, p + 1));
        cfg_en     = ($urandom_range(0, 7) != 0);
      end
      tick();
    end
    rst = 1'b0;
    idle(4);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
